// File: rtl/slot_index_pool.sv
// slot_index_pool
//
// Allocator for a 64-slot shared resource pool. A busy mask tracks which
// slots are owned. The lowest free slot is pre-reserved into an offer
// register and presented on a valid/ready port. Two independent free ports
// return slots. Each returned index is decoded to a one-hot clear of the
// busy mask. Illegal returns are rejected and flagged.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   alloc_valid   offer register holds a reserved slot index
//   alloc_idx     offered slot index
//   alloc_ready   consumer takes alloc_idx this cycle
//   free0_valid   return request on port 0; free0_idx is the slot returned
//   free1_valid   return request on port 1; free1_idx is the slot returned
//   free_count    number of clear bits in the busy mask (0..64)
//   hasany_free   free_count is non-zero
//   err_free      one-cycle pulse after a cycle that carried an illegal free
//
// Parameter
//   RESERVED_MASK slots that are busy from reset and can never be
//                 allocated or freed
module slot_index_pool #(
  parameter logic [63:0] RESERVED_MASK = 64'h0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       alloc_valid,
  output logic [5:0] alloc_idx,
  input  logic       alloc_ready,
  input  logic       free0_valid,
  input  logic [5:0] free0_idx,
  input  logic       free1_valid,
  input  logic [5:0] free1_idx,
  output logic [6:0] free_count,
  output logic       hasany_free,
  output logic       err_free
);

  function automatic logic [6:0] count_zeros(input logic [63:0] m);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (!m[i]) n = n + 7'd1;
    end
    return n;
  endfunction

  localparam logic [6:0] RESET_FREE = count_zeros(RESERVED_MASK);

  logic [63:0] busy_q, busy_d;
  logic        alloc_valid_q, alloc_valid_d;
  logic [5:0]  alloc_idx_q, alloc_idx_d;
  logic [6:0]  free_count_q, free_count_d;
  logic        err_free_q, err_free_d;

  logic        scan_found;
  logic [5:0]  scan_idx;
  logic        legal0, legal1;
  logic        handshake, load, took;
  logic [63:0] set_mask, clr_mask;

  // Lowest-index priority encoder over clear bits of the current mask.
  // Iterating downward lets the lowest hit overwrite higher ones.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (!busy_q[i]) begin
        scan_found = 1'b1;
        scan_idx   = 6'(i);
      end
    end
  end

  // A free is legal only if it returns an owned slot: the bit is set, the
  // slot is not reserved, and it is not the slot sitting in the offer
  // register (which the consumer does not own yet). When both ports name
  // the same slot, port 1 loses and counts as a double free.
  always_comb begin
    legal0 = free0_valid & busy_q[free0_idx] & ~RESERVED_MASK[free0_idx]
           & ~(alloc_valid_q & (free0_idx == alloc_idx_q));
    legal1 = free1_valid & busy_q[free1_idx] & ~RESERVED_MASK[free1_idx]
           & ~(alloc_valid_q & (free1_idx == alloc_idx_q))
           & ~(free0_valid & (free1_idx == free0_idx));
  end

  always_comb begin
    handshake     = alloc_valid_q & alloc_ready;
    load          = ~alloc_valid_q | handshake;
    took          = load & scan_found;
    set_mask      = 64'd0;
    clr_mask      = 64'd0;
    alloc_valid_d = alloc_valid_q;
    alloc_idx_d   = alloc_idx_q;

    // The scan uses the pre-edge mask, so a slot freed at this edge is
    // only visible to the scan at the following edge.
    if (load) begin
      alloc_valid_d = scan_found;
      if (scan_found) begin
        alloc_idx_d = scan_idx;
        set_mask    = 64'd1 << scan_idx;
      end
    end

    if (legal0) clr_mask = clr_mask | (64'd1 << free0_idx);
    if (legal1) clr_mask = clr_mask | (64'd1 << free1_idx);

    // Set and clear never target the same bit: the scan only picks clear
    // bits while a legal free only targets set bits.
    busy_d = (busy_q | set_mask) & ~clr_mask;

    free_count_d = free_count_q + 7'(legal0) + 7'(legal1) - 7'(took);
    err_free_d   = (free0_valid & ~legal0) | (free1_valid & ~legal1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= RESERVED_MASK;
      alloc_valid_q <= 1'b0;
      alloc_idx_q   <= 6'd0;
      free_count_q  <= RESET_FREE;
      err_free_q    <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_idx_q   <= alloc_idx_d;
      free_count_q  <= free_count_d;
      err_free_q    <= err_free_d;
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_idx   = alloc_idx_q;
  assign free_count  = free_count_q;
  assign hasany_free = (free_count_q != 7'd0);
  assign err_free    = err_free_q;

endmodule

// File: tb/tb_slot_index_pool.sv
// Testbench for slot_index_pool: a default instance exercised through
// drain, refill, illegal-free, backpressure and mid-run reset sequences, and
// a second instance with the low eight slots reserved. Expected handshake
// indices are queued by the stimulus and consumed by an independent monitor.
module tb_slot_index_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, alloc_ready, free0_valid, free1_valid;
  logic [5:0] free0_idx, free1_idx;
  logic       alloc_valid, hasany_free, err_free;
  logic [5:0] alloc_idx;
  logic [6:0] free_count;

  logic       r_rst, r_alloc_ready, r_free0_valid, r_free1_valid;
  logic [5:0] r_free0_idx, r_free1_idx;
  logic       r_alloc_valid, r_hasany_free, r_err_free;
  logic [5:0] r_alloc_idx;
  logic [6:0] r_free_count;

  slot_index_pool dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_ready(alloc_ready),
    .free0_valid(free0_valid), .free0_idx(free0_idx),
    .free1_valid(free1_valid), .free1_idx(free1_idx),
    .free_count(free_count), .hasany_free(hasany_free), .err_free(err_free)
  );

  slot_index_pool #(.RESERVED_MASK(64'h0000_0000_0000_00FF)) dut_r (
    .clk(clk), .rst(r_rst),
    .alloc_valid(r_alloc_valid), .alloc_idx(r_alloc_idx), .alloc_ready(r_alloc_ready),
    .free0_valid(r_free0_valid), .free0_idx(r_free0_idx),
    .free1_valid(r_free1_valid), .free1_idx(r_free1_idx),
    .free_count(r_free_count), .hasany_free(r_hasany_free), .err_free(r_err_free)
  );

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (err_free === 1'b1) err_seen++;
      if (alloc_valid === 1'b1 && alloc_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake got idx %0d expected no handshake", alloc_idx);
        end else begin
          chk("handshake_idx", 64'(alloc_idx), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; alloc_ready = 1'b0;
    free0_valid = 1'b0; free0_idx = 6'd0; free1_valid = 1'b0; free1_idx = 6'd0;
    r_rst = 1'b1; r_alloc_ready = 1'b0;
    r_free0_valid = 1'b0; r_free0_idx = 6'd0; r_free1_valid = 1'b0; r_free1_idx = 6'd0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 64'(alloc_valid), 64'd0);
    chk("rst_idx", 64'(alloc_idx), 64'd0);
    chk("rst_count", 64'(free_count), 64'd64);
    chk("rst_hasany", 64'(hasany_free), 64'd1);
    chk("rst_err", 64'(err_free), 64'd0);
    chk("res_rst_count", 64'(r_free_count), 64'd56);
    chk("res_rst_valid", 64'(r_alloc_valid), 64'd0);

    // Reserved slots
    r_rst = 1'b0;
    tick();
    chk("res_first_valid", 64'(r_alloc_valid), 64'd1);
    chk("res_first_idx", 64'(r_alloc_idx), 64'd8);
    chk("res_count", 64'(r_free_count), 64'd55);
    r_free0_valid = 1'b1; r_free0_idx = 6'd3;
    tick();
    r_free0_valid = 1'b0;
    chk("res_free_err", 64'(r_err_free), 64'd1);
    chk("res_free_count", 64'(r_free_count), 64'd55);
    tick();
    chk("res_err_clear", 64'(r_err_free), 64'd0);

    // Drain the pool
    for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
    rst = 1'b0; alloc_ready = 1'b1;
    repeat (70) tick();
    alloc_ready = 1'b0;
    chk("drain_valid", 64'(alloc_valid), 64'd0);
    chk("drain_count", 64'(free_count), 64'd0);
    chk("drain_hasany", 64'(hasany_free), 64'd0);
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);

    // Refill from full: 17 and 5 together, offers come back lowest first
    free0_valid = 1'b1; free0_idx = 6'd17; free1_valid = 1'b1; free1_idx = 6'd5;
    tick();
    free0_valid = 1'b0; free1_valid = 1'b0;
    chk("refill_count", 64'(free_count), 64'd2);
    chk("refill_valid_same_edge", 64'(alloc_valid), 64'd0);
    tick();
    chk("refill_offer_valid", 64'(alloc_valid), 64'd1);
    chk("refill_offer_idx", 64'(alloc_idx), 64'd5);
    chk("refill_offer_count", 64'(free_count), 64'd1);
    exp_q.push_back(6'd5); exp_q.push_back(6'd17);
    alloc_ready = 1'b1;
    tick(); tick();
    alloc_ready = 1'b0;
    chk("refill_end_valid", 64'(alloc_valid), 64'd0);
    chk("refill_end_count", 64'(free_count), 64'd0);
    chk("refill_queue_left", 64'(exp_q.size()), 64'd0);

    // Illegal frees: put slot 2 on offer and hold it
    free0_valid = 1'b1; free0_idx = 6'd2;
    tick();
    free0_valid = 1'b0;
    tick();
    chk("ill_offer_idx", 64'(alloc_idx), 64'd2);
    chk("ill_offer_count", 64'(free_count), 64'd0);

    // Both ports return 9: cleared once, one error pulse
    free0_valid = 1'b1; free0_idx = 6'd9; free1_valid = 1'b1; free1_idx = 6'd9;
    tick();
    free0_valid = 1'b0; free1_valid = 1'b0; exp_err++;
    chk("dup_err", 64'(err_free), 64'd1);
    chk("dup_count", 64'(free_count), 64'd1);
    tick();
    chk("dup_err_clear", 64'(err_free), 64'd0);
    chk("dup_err_pulses", 64'(err_seen), 64'(exp_err));

    // 9 returned again: double free
    free0_valid = 1'b1; free0_idx = 6'd9;
    tick();
    free0_valid = 1'b0; exp_err++;
    chk("dbl_err", 64'(err_free), 64'd1);
    chk("dbl_count", 64'(free_count), 64'd1);
    tick();
    chk("dbl_err_clear", 64'(err_free), 64'd0);
    chk("dbl_err_pulses", 64'(err_seen), 64'(exp_err));

    // Returning the slot currently on offer
    free1_valid = 1'b1; free1_idx = 6'd2;
    tick();
    free1_valid = 1'b0; exp_err++;
    chk("offered_err", 64'(err_free), 64'd1);
    chk("offered_count", 64'(free_count), 64'd1);
    chk("offered_valid", 64'(alloc_valid), 64'd1);
    chk("offered_idx", 64'(alloc_idx), 64'd2);
    tick();
    chk("offered_err_clear", 64'(err_free), 64'd0);
    chk("offered_err_pulses", 64'(err_seen), 64'(exp_err));

    // Backpressure: offer 2 held while 40, 30, 50 are returned
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin free0_valid = 1'b1; free0_idx = 6'd40; end
      else if (i == 1) begin free1_valid = 1'b1; free1_idx = 6'd30; end
      else if (i == 2) begin free0_valid = 1'b1; free0_idx = 6'd50; end
      tick();
      free0_valid = 1'b0; free1_valid = 1'b0;
      chk("bp_hold_idx", 64'(alloc_idx), 64'd2);
    end
    chk("bp_valid", 64'(alloc_valid), 64'd1);
    chk("bp_count", 64'(free_count), 64'd4);
    exp_q.push_back(6'd2); exp_q.push_back(6'd9);
    alloc_ready = 1'b1;
    tick(); tick();
    alloc_ready = 1'b0;
    chk("bp_next_idx", 64'(alloc_idx), 64'd30);
    chk("bp_next_count", 64'(free_count), 64'd2);
    chk("bp_queue_left", 64'(exp_q.size()), 64'd0);
    chk("bp_err_pulses", 64'(err_seen), 64'(exp_err));

    // Reset mid-operation: fresh start, 20 allocations with frees of 0 and 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i <= 6; i++) exp_q.push_back(6'(i));
    exp_q.push_back(6'd0); exp_q.push_back(6'd3);
    for (int i = 7; i <= 17; i++) exp_q.push_back(6'(i));
    alloc_ready = 1'b1;
    for (int t = 1; t <= 21; t++) begin
      if (t == 7) begin
        free0_valid = 1'b1; free0_idx = 6'd0; free1_valid = 1'b1; free1_idx = 6'd3;
      end
      tick();
      free0_valid = 1'b0; free1_valid = 1'b0;
    end
    chk("run_idx", 64'(alloc_idx), 64'd18);
    chk("run_count", 64'(free_count), 64'd45);
    chk("run_queue_left", 64'(exp_q.size()), 64'd0);

    rst = 1'b1;
    free0_valid = 1'b1; free0_idx = 6'd5; free1_valid = 1'b1; free1_idx = 6'd6;
    tick();
    free0_valid = 1'b0; free1_valid = 1'b0;
    chk("mid_rst_valid", 64'(alloc_valid), 64'd0);
    chk("mid_rst_idx", 64'(alloc_idx), 64'd0);
    chk("mid_rst_count", 64'(free_count), 64'd64);
    chk("mid_rst_hasany", 64'(hasany_free), 64'd1);
    chk("mid_rst_err", 64'(err_free), 64'd0);

    rst = 1'b0;
    exp_q.push_back(6'd0);
    tick();
    chk("post_rst_valid", 64'(alloc_valid), 64'd1);
    chk("post_rst_idx", 64'(alloc_idx), 64'd0);
    tick();
    alloc_ready = 1'b0;
    chk("post_rst_next_idx", 64'(alloc_idx), 64'd1);
    chk("post_rst_count", 64'(free_count), 64'd62);
    chk("final_queue_left", 64'(exp_q.size()), 64'd0);
    chk("final_err_pulses", 64'(err_seen), 64'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
